fft_out_serializer: RTL

//  Downstream neighbour of the 8-point pipelined FFT core. Waits out the core's pipeline latency after a

---
 rtl/fft_pkg.sv | 22 ++
 rtl/fft_byte_mux.sv | 28 ++
 rtl/fft_out_serializer.sv | 106 ++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared FFT constants, serializer state encoding and the res_flat packing helper.
// Anything that packs or unpacks the FFT result bus should use res_lsb.
package fft_pkg;

    localparam int FFT_N       = 8;
    localparam int FFT_W       = 12;
    localparam int FFT_LATENCY = 3;
    localparam int FFT_OUT_W   = 8;
    localparam int FFT_IDX_W   = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SEND
    } ser_state_e;

    // Bit position of the LSB of ak_re (im=0) or ak_im (im=1) inside res_flat.
    function automatic int res_lsb(input int k, input int w, input bit im);
        return 2 * w * k + (im ? w : 0);
    endfunction

endpackage

// File: rtl/fft_byte_mux.sv
// Selects one byte of the captured word array: the low byte of the word on even
// indices, and the sign-extended upper bits of the word on odd indices.
module fft_byte_mux
    import fft_pkg::*;
#(
    parameter int N_PTS = FFT_N,
    parameter int W     = FFT_W,
    parameter int OUT_W = FFT_OUT_W,
    parameter int IDX_W = FFT_IDX_W
) (
    input  logic [2*N_PTS-1:0][W-1:0] words,
    input  logic [IDX_W-1:0]          idx,
    output logic [OUT_W-1:0]          data
);

    localparam int SEL_W = $clog2(2 * N_PTS);

    logic [SEL_W-1:0]   sel;
    logic [W-1:0]       word;
    logic [2*OUT_W-1:0] word_ext;

    assign sel      = idx[SEL_W:1];
    assign word     = words[sel];
    // Widening a signed value replicates the sign bit into the upper byte.
    assign word_ext = (2*OUT_W)'(signed'(word));
    assign data     = idx[0] ? word_ext[2*OUT_W-1:OUT_W] : word_ext[OUT_W-1:0];

endmodule

// File: rtl/fft_out_serializer.sv
// Waits out the FFT pipeline latency after start, snapshots all results and
// streams them as bytes over a valid/ready interface.
module fft_out_serializer
    import fft_pkg::*;
#(
    parameter int N_PTS   = FFT_N,
    parameter int W       = FFT_W,
    parameter int OUT_W   = FFT_OUT_W,
    parameter int LATENCY = FFT_LATENCY
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N_PTS*2*W-1:0] res_flat,
    output logic [OUT_W-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy
);

    localparam int CNT_W   = $clog2(LATENCY + 1);
    localparam int N_BYTES = 4 * N_PTS;
    localparam logic [FFT_IDX_W-1:0] LAST_IDX = FFT_IDX_W'(N_BYTES - 1);
    localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

    ser_state_e               state, state_d;
    logic [CNT_W-1:0]         cnt, cnt_d;
    logic [FFT_IDX_W-1:0]     idx, idx_d;
    logic [2*N_PTS-1:0][W-1:0] cap, cap_in;
    logic                     cap_ld;
    logic [OUT_W-1:0]         mux_data;

    for (genvar k = 0; k < N_PTS; k++) begin : g_unpack
        assign cap_in[2*k]   = res_flat[res_lsb(k, W, 1'b0) +: W];
        assign cap_in[2*k+1] = res_flat[res_lsb(k, W, 1'b1) +: W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            cap   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            if (cap_ld)
                cap <= cap_in;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        cap_ld  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt - CNT_ONE;
                // Counter reads 1 on the edge LATENCY edges after start.
                if (cnt == CNT_ONE) begin
                    cap_ld  = 1'b1;
                    state_d = ST_SEND;
                    idx_d   = '0;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (idx == LAST_IDX) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx + FFT_IDX_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    fft_byte_mux #(
        .N_PTS (N_PTS),
        .W     (W),
        .OUT_W (OUT_W),
        .IDX_W (FFT_IDX_W)
    ) u_byte_mux (
        .words (cap),
        .idx   (idx),
        .data  (mux_data)
    );

    assign out_valid = (state == ST_SEND);
    assign out_last  = out_valid && (idx == LAST_IDX);
    assign busy      = (state != ST_IDLE);
    assign out_data  = out_valid ? mux_data : '0;

endmodule
